andor_arbiter: RTL and testbench

ANDOR_ARBITER -- requirements
Module: andor_arbiter

---
 rtl/andor_arbiter.sv | 111 +++++++++++
 tb/tb_andor_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/andor_arbiter.sv
// Two-requester round-robin arbiter in front of one shared (a&b)|c unit.
// The result sits in a one-entry register and follows a valid/ready handshake.
module andor_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req0_c,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [W-1:0] req1_c,

    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_and,
    output logic [W-1:0] res_data,
    output logic         res_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q;
    logic           prio_q;
    logic [W-1:0]   and_q;
    logic [W-1:0]   data_q;
    logic           id_q;

    logic           slot_free;
    logic           gnt0;
    logic           gnt1;
    logic           accept;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [W-1:0]   sel_c;
    logic [W-1:0]   and_d;
    logic [W-1:0]   data_d;

    function automatic logic [W-1:0] and_or(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W-1:0] c);
        return (a & b) | c;
    endfunction

    // Grants depend only on valids, prio and slot occupancy; gated by rst_n so
    // both ready outputs read 0 while reset is asserted.
    always_comb begin
        slot_free = (state_q == EMPTY) || res_ready;
        gnt0      = rst_n && slot_free && req0_valid && (!req1_valid || !prio_q);
        gnt1      = rst_n && slot_free && req1_valid && (!req0_valid ||  prio_q);
        accept    = gnt0 || gnt1;
        sel_a     = gnt1 ? req1_a : req0_a;
        sel_b     = gnt1 ? req1_b : req0_b;
        sel_c     = gnt1 ? req1_c : req0_c;
        and_d     = sel_a & sel_b;
        data_d    = and_or(sel_a, sel_b, sel_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            prio_q  <= 1'b0;
            and_q   <= '0;
            data_q  <= '0;
            id_q    <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                        prio_q  <= !gnt1;
                        and_q   <= and_d;
                        data_q  <= data_d;
                        id_q    <= gnt1;
                    end
                end
                FULL: begin
                    // A drain with a waiting requester refills on the same edge.
                    if (accept) begin
                        state_q <= FULL;
                        prio_q  <= !gnt1;
                        and_q   <= and_d;
                        data_q  <= data_d;
                        id_q    <= gnt1;
                    end else if (res_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign res_valid  = (state_q == FULL);
    assign res_and    = and_q;
    assign res_data   = data_q;
    assign res_id     = id_q;

endmodule

// File: tb/tb_andor_arbiter.sv
// Bench for andor_arbiter: table of per-cycle vectors, reset corner sequences,
// and a random phase, with a result scoreboard fed from a reference model.
module tb_andor_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req0_c;
    logic [W-1:0] req1_a, req1_b, req1_c;
    logic         res_valid, res_ready, res_id;
    logic [W-1:0] res_and, res_data;

    andor_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_c     (req0_c),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_c     (req1_c),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_and    (res_and),
        .res_data   (res_data),
        .res_id     (res_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v0, v1, rr;
        logic [W-1:0] a0, b0, c0, a1, b1, c1;
        logic         r0, r1, rv;
    } vec_t;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] d;
    } res_t;

    localparam int NVEC = 19;
    vec_t tbl [NVEC];
    res_t sbq [$];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic m_full = 1'b0;
    logic m_prio = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic v1, input logic rr,
                                input logic r0, input logic r1, input logic rv);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.rr = rr;
        v.r0 = r0; v.r1 = r1; v.rv = rv;
        v.a0 = '0; v.b0 = '0; v.c0 = '0; v.a1 = '0; v.b1 = '0; v.c1 = '0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        req0_valid = v.v0; req1_valid = v.v1; res_ready = v.rr;
        req0_a = v.a0; req0_b = v.b0; req0_c = v.c0;
        req1_a = v.a1; req1_b = v.b1; req1_c = v.c1;
        #2;
    endtask

    // Called mid-cycle with inputs settled: checks the DUT against the model,
    // then advances the model to the state after the coming rising edge.
    task automatic check_model();
        logic sf, e0, e1;
        res_t r;
        sf = !m_full || res_ready;
        e0 = sf && req0_valid && (!req1_valid || !m_prio);
        e1 = sf && req1_valid && (!req0_valid ||  m_prio);
        chk("m_req0_ready", req0_ready, e0);
        chk("m_req1_ready", req1_ready, e1);
        chk("ready_onehot", req0_ready & req1_ready, 0);
        chk("m_res_valid", res_valid, m_full);
        if (m_full) begin
            chk("sb_depth", sbq.size(), 1);
            if (sbq.size() > 0) begin
                chk("sb_res_id", res_id, sbq[0].id);
                chk("sb_res_and", res_and, sbq[0].a);
                chk("sb_res_data", res_data, sbq[0].d);
                if (res_ready) void'(sbq.pop_front());
            end
        end
        if (e0 || e1) begin
            r.id = e1;
            r.a  = e1 ? (req1_a & req1_b) : (req0_a & req0_b);
            r.d  = e1 ? ((req1_a & req1_b) | req1_c) : ((req0_a & req0_b) | req0_c);
            sbq.push_back(r);
            m_prio = !e1;
            m_full = 1'b1;
        end else if (m_full && res_ready) begin
            m_full = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_and"}, res_and, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_id"}, res_id, 0);
        chk({tag, "_req0_ready"}, req0_ready, 0);
        chk({tag, "_req1_ready"}, req1_ready, 0);
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_prio = 1'b0;
        sbq.delete();
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; res_ready = 0;
        req0_a = 0; req0_b = 0; req0_c = 0; req1_a = 0; req1_b = 0; req1_c = 0;

        //             v0 v1 rr  r0 r1 rv
        tbl[0]  = mk(1, 0, 1,  1, 0, 0);  // single request from 0
        tbl[1]  = mk(0, 0, 1,  0, 0, 1);  // drain to empty
        tbl[2]  = mk(0, 0, 1,  0, 0, 0);
        tbl[3]  = mk(1, 1, 1,  0, 1, 0);  // prio is 1 after the first accept
        tbl[4]  = mk(1, 1, 1,  1, 0, 1);
        tbl[5]  = mk(1, 1, 1,  0, 1, 1);
        tbl[6]  = mk(1, 1, 1,  1, 0, 1);
        tbl[7]  = mk(1, 1, 0,  0, 0, 1);  // backpressure x5
        tbl[8]  = mk(1, 1, 0,  0, 0, 1);
        tbl[9]  = mk(1, 1, 0,  0, 0, 1);
        tbl[10] = mk(1, 1, 0,  0, 0, 1);
        tbl[11] = mk(1, 1, 0,  0, 0, 1);
        tbl[12] = mk(1, 1, 1,  0, 1, 1);  // drain and refill with prio requester
        tbl[13] = mk(0, 1, 1,  0, 1, 1);  // lone requester wins against prio
        tbl[14] = mk(0, 0, 1,  0, 0, 1);
        tbl[15] = mk(0, 0, 0,  0, 0, 0);
        tbl[16] = mk(1, 0, 0,  1, 0, 0);  // empty slot accepts despite res_ready=0
        tbl[17] = mk(1, 0, 0,  0, 0, 1);
        tbl[18] = mk(0, 0, 1,  0, 0, 1);
        for (int i = 1; i < NVEC; i++) begin
            tbl[i].a0 = W'(i * 37 + 5);  tbl[i].b0 = W'(i * 91 + 17); tbl[i].c0 = W'(i * 3);
            tbl[i].a1 = W'(i * 53 + 9);  tbl[i].b1 = W'(i * 29 + 70); tbl[i].c1 = W'(i << 2);
        end
        tbl[0].a0 = 8'hF0; tbl[0].b0 = 8'h3C; tbl[0].c0 = 8'h01;

        // Reset state
        #1;
        chk_all_zero("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply(tbl[i]);
            chk($sformatf("tbl%0d_req0_ready", i), req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_req1_ready", i), req1_ready, tbl[i].r1);
            chk($sformatf("tbl%0d_res_valid", i), res_valid, tbl[i].rv);
            if (i == 1) begin
                chk("single_res_and", res_and, 8'h30);
                chk("single_res_data", res_data, 8'h31);
                chk("single_res_id", res_id, 0);
            end
            check_model();
        end

        // Reset while FULL under backpressure with both requesters valid
        v = mk(1, 1, 0, 0, 0, 0);
        v.a0 = 8'hFF; v.b0 = 8'hAA; v.c0 = 8'h01; v.a1 = 8'h0F; v.b1 = 8'hFF; v.c1 = 8'h10;
        apply(v); check_model();
        apply(v); check_model();
        chk("pre_rst_full", res_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; res_ready = 1;
        #2 rst_n = 1'b1;
        v = mk(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(v);
            chk("post_rst_no_valid", res_valid, 0);
            check_model();
        end
        // prio restarts at 0 after reset
        v = mk(1, 1, 1, 1, 0, 0);
        v.a0 = 8'h5A; v.b0 = 8'hF0; v.c0 = 8'h03; v.a1 = 8'hC3; v.b1 = 8'h3C; v.c1 = 8'h80;
        apply(v);
        chk("post_rst_prio0", req0_ready, 1);
        check_model();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            v = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) != 0), 0, 0, 0);
            v.a0 = W'($urandom); v.b0 = W'($urandom); v.c0 = W'($urandom);
            v.a1 = W'($urandom); v.b1 = W'($urandom); v.c1 = W'($urandom);
            apply(v);
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
